correlator_sched_ctrl: RTL and testbench
========================================

Name: correlator_sched_ctrl

Overview:
- Command-driven scheduler and configurator for the correlator datapath.
- Decodes UART command bytes into configuration: per-input delay taps, LEDs, baud-rate divider select, capture enable and integration period.
- Generates the integration boundary: snapshot strobe, counter-clear strobe and TX frame start.
- Applies staged delay configuration atomically at integration boundaries, so one integration never mixes old and new delays.

Parameters:
- NUM_INPUTS, 4, number of telescope inputs (delay channels).
- DELAY_WIDTH, 20, bits per delay tap select (MAX_DELAY = 2^20).
- PERIOD_WIDTH, 32, width of integration period counter in clk cycles.
- DEFAULT_PERIOD, 50000000, integration period after reset (clk cycles).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  received UART byte; [3:0] opcode, [7:4] argument nibble.
- rx_valid  input  1  one-cycle strobe, rx_data valid (already synchronised to clk).
- tx_busy  input  1  frame transmitter busy.
- delay_flat  output  NUM_INPUTS*DELAY_WIDTH  active delay per input, input i at [i*DELAY_WIDTH+:DELAY_WIDTH].
- leds  output  32  LED drive, 2 bits per index.
- baud_rate  output  4  baud divider shift select.
- transmit_enable  output  1  capture/stream enable.
- integration_pulse  output  1  one-cycle snapshot strobe.
- counter_reset  output  1  one-cycle clear of pulse counters, the cycle after integration_pulse.
- tx_start  output  1  one-cycle frame start request.
- overrun_count  output  8  saturating count of frames dropped because tx_busy was high.

Behaviour:
- Reset values:
  - delay_flat, staged delays and leds are 0.
  - baud_rate, transmit_enable, integration_pulse, counter_reset, tx_start and overrun_count are 0.
  - index=0, nibble pointer=0, period=DEFAULT_PERIOD, timer=0.
- Opcodes are acted on in the cycle rx_valid=1; registered outputs update the next cycle. Bytes arriving while rx_valid=0 are ignored.
  - 0 CLEAR: nibble pointer←0.
  - 1 SET_INDEX: index←arg.
  - 2 SET_LEDS: leds[index*2+:2]←arg[1:0]. Ignored if index>15.
  - 3 SET_BAUD_RATE: baud_rate←arg.
  - 4 SET_DELAY: staged[index][ptr*4+:4]←arg, ptr←ptr+1.
    - ptr wraps to 0 after the last nibble (ceil(DELAY_WIDTH/4)-1); bits beyond DELAY_WIDTH are discarded.
    - index≥NUM_INPUTS: write discarded, ptr still advances.
  - 5 SET_PERIOD: period shift register ← {period[PERIOD_WIDTH-5:0], arg}. Takes effect at the next boundary.
  - 13 ENABLE_CAPTURE: transmit_enable←arg[0].
  - All other opcodes: no effect.
- Timer:
  - Counts 0..period-1. At count==period-1: integration_pulse=1 for that cycle and timer←0.
  - period==0: timer held at 0, no pulses.
  - period==1: pulse every cycle.
- At integration_pulse (same edge):
  - delay_flat←staged.
  - Pending period value is adopted.
  - counter_reset asserted the following cycle.
- TX handshake:
  - At integration_pulse with transmit_enable=1: if tx_busy=0, tx_start=1 for that cycle; otherwise no tx_start and overrun_count←min(overrun_count+1,255).
  - transmit_enable=0 gives no tx_start and no overrun.
- Simultaneous events:
  - SET_DELAY on the boundary cycle is not part of that snapshot; it is applied at the next boundary.
  - ENABLE_CAPTURE on the boundary cycle uses the old transmit_enable.
- reset mid-integration: all state returns to reset values the next cycle; any pending staged values are lost.

Optional Feature:
- CMD_ACK_EN defined: adds outputs ack_data[7:0] and ack_valid.
  - One cycle after each accepted rx_valid: ack_valid=1, ack_data={index,opcode}.
  - Unknown opcode: ack_data=8'hFF.
- Not defined: ports absent, no acknowledge logic.

Test Plan:
- Reset → delay_flat=0, leds=0, period=50000000, no integration_pulse for 49999999 cycles, pulse on cycle 50000000.
- SET_PERIOD nibbles 0,0,0,0,0,0,1,4 (period 0x14=20) → after the current boundary, integration_pulse every 20 cycles; counter_reset exactly 1 cycle after each pulse.
- SET_INDEX 2, CLEAR, SET_DELAY nibbles 5,A,3,0,0 → staged[2]=0x03A5; delay_flat[40+:20] stays 0 until the next integration_pulse, then reads 0x003A5.
- SET_DELAY six nibbles with index=2 → pointer wraps, sixth nibble overwrites bits [3:0]; SET_INDEX 7 then SET_DELAY → delay_flat unchanged.
- ENABLE_CAPTURE arg=1, tx_busy held 1 across 3 boundaries → no tx_start, overrun_count=3; tx_busy=0 → tx_start at the next boundary.
- Assert reset during a SET_DELAY sequence with period=20 → all outputs 0, period back to DEFAULT_PERIOD, no tx_start.

Source files
------------

// File: rtl/correlator_sched_ctrl.sv
// Correlator scheduler: decodes UART command bytes into configuration and generates integration boundaries.
// Optional command acknowledge outputs (ack_data/ack_valid) are built when CMD_ACK_EN is defined.
module correlator_sched_ctrl #(
  parameter int              NUM_INPUTS     = 4,
  parameter int              DELAY_WIDTH    = 20,
  parameter int              PERIOD_WIDTH   = 32,
  parameter longint unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  input  logic                              tx_busy,
  output logic [NUM_INPUTS*DELAY_WIDTH-1:0] delay_flat,
  output logic [31:0]                       leds,
  output logic [3:0]                        baud_rate,
  output logic                              transmit_enable,
  output logic                              integration_pulse,
  output logic                              counter_reset,
  output logic                              tx_start,
  output logic [7:0]                        overrun_count
`ifdef CMD_ACK_EN
  ,
  output logic [7:0]                        ack_data,
  output logic                              ack_valid
`endif
);

  localparam int NIBBLES = (DELAY_WIDTH + 3) / 4;
  localparam int PTR_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [PERIOD_WIDTH-1:0] RESET_PERIOD = PERIOD_WIDTH'(DEFAULT_PERIOD);
  localparam logic [PTR_W-1:0]        LAST_PTR     = PTR_W'(NIBBLES - 1);

  localparam logic [3:0] OP_CLEAR          = 4'd0;
  localparam logic [3:0] OP_SET_INDEX      = 4'd1;
  localparam logic [3:0] OP_SET_LEDS       = 4'd2;
  localparam logic [3:0] OP_SET_BAUD_RATE  = 4'd3;
  localparam logic [3:0] OP_SET_DELAY      = 4'd4;
  localparam logic [3:0] OP_SET_PERIOD     = 4'd5;
  localparam logic [3:0] OP_ENABLE_CAPTURE = 4'd13;

  logic [3:0]              opcode;
  logic [3:0]              arg;
  logic [DELAY_WIDTH-1:0]  staged [NUM_INPUTS];
  logic [3:0]              index;
  logic [PTR_W-1:0]        ptr;
  logic [PERIOD_WIDTH-1:0] period;
  logic [PERIOD_WIDTH-1:0] period_pending;
  logic [PERIOD_WIDTH-1:0] timer;
  logic                    boundary;

  assign opcode = rx_data[3:0];
  assign arg    = rx_data[7:4];

  assign boundary          = (period != '0) && (timer == period - PERIOD_WIDTH'(1));
  assign integration_pulse = boundary;
  assign tx_start          = boundary && transmit_enable && !tx_busy;

  // Nibbles that land past DELAY_WIDTH fall off when the result is truncated.
  function automatic logic [DELAY_WIDTH-1:0] put_nibble(
    input logic [DELAY_WIDTH-1:0] cur,
    input logic [PTR_W-1:0]       pos,
    input logic [3:0]             nib
  );
    logic [NIBBLES*4-1:0] ext;
    ext = '0;
    ext[DELAY_WIDTH-1:0] = cur;
    for (int k = 0; k < NIBBLES; k++) begin
      if (int'(pos) == k) ext[k*4 +: 4] = nib;
    end
    return ext[DELAY_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      timer         <= '0;
      period        <= RESET_PERIOD;
      counter_reset <= 1'b0;
      overrun_count <= '0;
      delay_flat    <= '0;
    end else begin
      counter_reset <= boundary;
      if (boundary) begin
        timer  <= '0;
        period <= period_pending;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          delay_flat[i*DELAY_WIDTH +: DELAY_WIDTH] <= staged[i];
        end
        if (transmit_enable && tx_busy && overrun_count != 8'hFF) begin
          overrun_count <= overrun_count + 8'd1;
        end
      end else if (period == '0) begin
        // No boundaries will ever occur at period 0, so let a new period take hold directly.
        timer  <= '0;
        period <= period_pending;
      end else begin
        timer <= timer + PERIOD_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index           <= '0;
      ptr             <= '0;
      leds            <= '0;
      baud_rate       <= '0;
      transmit_enable <= 1'b0;
      period_pending  <= RESET_PERIOD;
      for (int i = 0; i < NUM_INPUTS; i++) staged[i] <= '0;
    end else if (rx_valid) begin
      case (opcode)
        OP_CLEAR:         ptr <= '0;
        OP_SET_INDEX:     index <= arg;
        OP_SET_LEDS: begin
          for (int j = 0; j < 16; j++) begin
            if (int'(index) == j) leds[j*2 +: 2] <= arg[1:0];
          end
        end
        OP_SET_BAUD_RATE: baud_rate <= arg;
        OP_SET_DELAY: begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            if (int'(index) == i) staged[i] <= put_nibble(staged[i], ptr, arg);
          end
          ptr <= (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
        end
        OP_SET_PERIOD:     period_pending <= {period_pending[PERIOD_WIDTH-5:0], arg};
        OP_ENABLE_CAPTURE: transmit_enable <= arg[0];
        default: ;
      endcase
    end
  end

`ifdef CMD_ACK_EN
  logic known_op;

  always_comb begin
    known_op = 1'b0;
    case (opcode)
      OP_CLEAR, OP_SET_INDEX, OP_SET_LEDS, OP_SET_BAUD_RATE,
      OP_SET_DELAY, OP_SET_PERIOD, OP_ENABLE_CAPTURE: known_op = 1'b1;
      default: known_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_valid <= 1'b0;
      ack_data  <= '0;
    end else begin
      ack_valid <= rx_valid;
      if (rx_valid) ack_data <= known_op ? {index, opcode} : 8'hFF;
    end
  end
`endif

endmodule

// File: tb/tb_correlator_sched_ctrl.sv
// Bench for correlator_sched_ctrl; reset period shortened to 300 cycles to keep runs short.
module tb_correlator_sched_ctrl;
  localparam int DEF = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic [79:0] delay_flat;
  logic [31:0] leds;
  logic [3:0]  baud_rate;
  logic        transmit_enable;
  logic        integration_pulse;
  logic        counter_reset;
  logic        tx_start;
  logic [7:0]  overrun_count;

  correlator_sched_ctrl #(
    .NUM_INPUTS(4), .DELAY_WIDTH(20), .PERIOD_WIDTH(32), .DEFAULT_PERIOD(DEF)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .delay_flat(delay_flat), .leds(leds), .baud_rate(baud_rate),
    .transmit_enable(transmit_enable), .integration_pulse(integration_pulse),
    .counter_reset(counter_reset), .tx_start(tx_start), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: configuration as plain integers, the timer as "cycles since last boundary".
  int unsigned m_delay [4];
  int unsigned m_staged [4];
  int unsigned m_leds, m_baud, m_te, m_over, m_index, m_ptr, m_period, m_pend, m_count;
  bit          m_cr;

  bit   obs_pulse, obs_tx, obs_cr;
  int   tx_count = 0;
  logic busy_lvl = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_delay[i]  = 0;
      m_staged[i] = 0;
    end
    m_leds = 0; m_baud = 0; m_te = 0; m_over = 0; m_index = 0; m_ptr = 0;
    m_period = DEF; m_pend = DEF; m_count = 0; m_cr = 0;
  endtask

  task automatic model_advance(input bit pulse, input logic v, input logic [7:0] d, input logic b);
    int unsigned op, a, sh;
    m_cr = pulse;
    if (pulse) begin
      for (int i = 0; i < 4; i++) m_delay[i] = m_staged[i];
      if (m_te == 1 && b && m_over < 255) m_over++;
      m_period = m_pend;
      m_count  = 0;
    end else if (m_period == 0) begin
      m_period = m_pend;
      m_count  = 0;
    end else begin
      m_count++;
    end
    if (v) begin
      op = 32'(d[3:0]);
      a  = 32'(d[7:4]);
      case (op)
        0:  m_ptr = 0;
        1:  m_index = a;
        2:  m_leds = (m_leds & ~(32'h3 << (2 * m_index))) | ((a & 3) << (2 * m_index));
        3:  m_baud = a;
        4: begin
          if (m_index < 4) begin
            sh = 4 * m_ptr;
            m_staged[m_index] = ((m_staged[m_index] & ~(32'hF << sh)) | (a << sh)) & 32'hFFFFF;
          end
          m_ptr = (m_ptr + 1) % 5;
        end
        5:  m_pend = (m_pend << 4) | a;
        13: m_te = a & 1;
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic b);
    bit          pulse;
    logic [79:0] exp_delay;
    reset = r; rx_valid = v; rx_data = d; tx_busy = b;
    @(negedge clk);
    pulse = (m_period != 0) && (m_count == m_period - 1);
    for (int i = 0; i < 4; i++) exp_delay[i*20 +: 20] = 20'(m_delay[i]);
    check("integration_pulse", integration_pulse, pulse);
    check("tx_start", tx_start, pulse && m_te == 1 && !b);
    check("counter_reset", counter_reset, m_cr);
    check("delay_flat", delay_flat, exp_delay);
    check("leds", leds, m_leds);
    check("baud_rate", baud_rate, m_baud);
    check("transmit_enable", transmit_enable, m_te);
    check("overrun_count", overrun_count, m_over);
    obs_pulse = integration_pulse;
    obs_tx    = tx_start;
    obs_cr    = counter_reset;
    if (obs_tx) tx_count++;
    if (r) model_reset();
    else model_advance(pulse, v, d, b);
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [7:0] d);
    step(1'b0, 1'b1, d, busy_lvl);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'($urandom), busy_lvl);
  endtask

  task automatic wait_pulse(input string tag, input int bound, output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (!obs_pulse && n < bound);
    check(tag, obs_pulse, 1'b1);
  endtask

  task automatic program_period(input logic [31:0] val);
    for (int k = 7; k >= 0; k--) cmd({val[k*4 +: 4], 4'h5});
  endtask

  initial begin
    int n, tx0;
    logic [3:0] op;

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();

    // Reset state and default period.
    check("rst_delay_flat", delay_flat, 80'h0);
    check("rst_leds", leds, 32'h0);
    wait_pulse("first_pulse_seen", DEF + 50, n);
    check("first_pulse_cycle", n, DEF);

    // Period 20 programmed nibble by nibble; adopted at the following boundary.
    program_period(32'h14);
    wait_pulse("period20_adopt", DEF + 50, n);
    for (int r = 0; r < 3; r++) begin
      idle();
      check("cr_after_pulse", obs_cr, 1'b1);
      wait_pulse("period20_seen", 60, n);
      check("period20_interval", n + 1, 20);
    end

    // Staged delay only becomes active at the boundary.
    cmd(8'h21); cmd(8'h00);
    cmd(8'h54); cmd(8'hA4); cmd(8'h34); cmd(8'h04); cmd(8'h04);
    check("delay_held_until_boundary", delay_flat[59:40], 20'h0);
    wait_pulse("delay_boundary", 60, n);
    check("delay_applied", delay_flat[59:40], 20'h003A5);
    cmd(8'h14); cmd(8'h24); cmd(8'h34); cmd(8'h44); cmd(8'h54); cmd(8'h64);
    wait_pulse("wrap_boundary", 60, n);
    check("delay_wrap", delay_flat[59:40], 20'h54326);
    cmd(8'h71); cmd(8'h94);
    wait_pulse("oob_boundary", 60, n);
    check("delay_oob_index", delay_flat, 80'h00000_54326_00000_00000);

    // Busy transmitter drops frames and counts overruns.
    busy_lvl = 1'b1;
    cmd(8'h1D);
    tx0 = tx_count;
    for (int r = 0; r < 3; r++) wait_pulse("busy_boundary", 60, n);
    check("busy_no_tx", tx_count - tx0, 0);
    check("overrun3", overrun_count, 8'd3);
    busy_lvl = 1'b0;
    wait_pulse("free_boundary", 60, n);
    check("tx_after_busy", obs_tx, 1'b1);

    // Randomised commands; small periods reprogrammed only just after a boundary.
    for (int c = 0; c < 2500; c++) begin
      busy_lvl = 1'($urandom_range(0, 1));
      if (obs_pulse && $urandom_range(0, 29) == 0) begin
        program_period(32'($urandom_range(10, 40)));
      end else begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd5) op = 4'd4;
        step(1'b0, ($urandom_range(0, 2) == 0), {4'($urandom_range(0, 15)), op}, busy_lvl);
      end
    end

    // Reset in the middle of a delay sequence.
    busy_lvl = 1'b0;
    wait_pulse("pre_reset_boundary", 60, n);
    program_period(32'h14);
    wait_pulse("pre_reset_adopt", 60, n);
    wait_pulse("pre_reset_period", 60, n);
    cmd(8'h11); cmd(8'h74); cmd(8'h84);
    step(1'b1, 1'b1, 8'h94, busy_lvl);
    check("post_rst_delay", delay_flat, 80'h0);
    check("post_rst_leds", leds, 32'h0);
    check("post_rst_overrun", overrun_count, 8'h0);
    check("post_rst_enable", transmit_enable, 1'b0);
    tx0 = tx_count;
    wait_pulse("post_rst_pulse", DEF + 50, n);
    check("post_rst_period", n, DEF);
    check("post_rst_no_tx", tx_count - tx0, 0);
    wait_pulse("post_rst_staged_lost", DEF + 50, n);
    check("post_rst_staged_lost_val", delay_flat, 80'h0);

    // Period 1 pulses every cycle; overrun saturates.
    program_period(32'h1);
    wait_pulse("period1_adopt", DEF + 50, n);
    for (int r = 0; r < 5; r++) begin
      idle();
      check("period1_pulse", obs_pulse, 1'b1);
    end
    cmd(8'h1D);
    busy_lvl = 1'b1;
    repeat (270) idle();
    check("overrun_saturate", overrun_count, 8'hFF);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
